// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared definitions for the UART transmit scheduler: the FSM state
//   encoding and the UART RW strobe levels.
//   No ports (package).
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } sched_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
//   Bundles the requester handshake and the UART bus-side signals of the
//   transmit scheduler.
//   Signals:
//     i_req          requester byte-valid, one bit per requester
//     i_data         packed bytes, requester k on [8k+7:8k]
//     i_lock         packet-mode hold request, one bit per requester
//     o_ack          one-cycle capture pulse per requester
//     o_grant        one-hot current owner, 0 when none
//     o_uart_data_ce UART data-register chip enable
//     o_uart_rw      UART RW strobe (0 = write, 1 = read/idle)
//     o_uart_wdata   byte presented to the UART
//     i_uart_busy    UART transmit-busy status bit
//   Modports: slave = scheduler side, master = requesters + UART side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]   i_lock;
  logic [NUM_REQ-1:0]   o_ack;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_uart_data_ce;
  logic                 o_uart_rw;
  logic [7:0]           o_uart_wdata;
  logic                 i_uart_busy;

  modport slave (
    input  i_req, i_data, i_lock, i_uart_busy,
    output o_ack, o_grant, o_uart_data_ce, o_uart_rw, o_uart_wdata
  );

  modport master (
    output i_req, i_data, i_lock, i_uart_busy,
    input  o_ack, o_grant, o_uart_data_ce, o_uart_rw, o_uart_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin selector with packet lock.
//   Ports:
//     req    in  NUM_REQ  request vector
//     ptr    in  IDX_W    last-served index; search starts at ptr+1
//     lock   in  1        only 'owner' may win while set
//     owner  in  IDX_W    current lock owner
//     valid  out 1        a winner exists
//     grant  out NUM_REQ  one-hot winner
//     idx    out IDX_W    winner index
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       lock,
  input  logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // While locked the owner is the only candidate, even if it is not
  // requesting right now; otherwise the first request above the pointer
  // wins, wrapping around so the pointer itself is searched last.
  always_comb begin
    int             cand;
    logic [IDX_W-1:0] cand_idx;
    valid    = 1'b0;
    grant    = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    if (lock) begin
      if (req[owner]) begin
        valid        = 1'b1;
        grant[owner] = 1'b1;
        idx          = owner;
      end
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand     = (int'(ptr) + i) % NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!valid && req[cand_idx]) begin
          valid           = 1'b1;
          grant[cand_idx] = 1'b1;
          idx             = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one byte-wide UART transmitter among NUM_REQ requesters.
//   Round-robin arbitration with optional per-requester packet lock. For
//   each byte: capture + ack, one write strobe to the UART data register,
//   then wait for the UART busy flag to rise and fall again.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous active-high reset
//     bus       slave modport of uart_tx_scheduler_if (requesters + UART)
//     o_active  out  high whenever the FSM is not in IDLE
//     o_err     out  one-cycle watchdog abort pulse
//   Build option:
//     UART_SCHED_TIMEOUT_EN  enables the TIMEOUT_CYCLES watchdog on both
//                            UART wait states; without it o_err is 0.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_scheduler_if.slave bus,
  output logic               o_active,
  output logic               o_err
);
  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t       state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic               lock_q;

  logic               arb_lock;
  logic [IDX_W-1:0]   arb_ptr;
  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [7:0]         sel_byte;

  // The lock only holds while the owner keeps i_lock up. Once it drops,
  // arbitration runs normally in the same cycle with the pointer at the
  // owner, because the pointer was frozen during the packet.
  assign arb_lock = lock_q & bus.i_lock[owner];
  assign arb_ptr  = lock_q ? owner : rr_ptr;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (bus.i_req),
    .ptr  (arb_ptr),
    .lock (arb_lock),
    .owner(owner),
    .valid(arb_valid),
    .grant(arb_grant),
    .idx  (arb_idx)
  );

  // Byte of the winning requester, picked by the one-hot grant.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) sel_byte = bus.i_data[8*k +: 8];
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;
  logic            wd_expired;

  // The counter runs only while the FSM sits in a UART wait state without
  // leaving it, so every entry into a wait state starts from zero.
  assign wd_run     = ((state == WAIT_BUSY) && !bus.i_uart_busy) ||
                      ((state == WAIT_IDLE) &&  bus.i_uart_busy);
  assign wd_expired = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build: the UART waits are unbounded and no abort
  // is ever reported; the limit has no effect here.
  assign o_err = (TIMEOUT_CYCLES < 0);
`endif

  // Main scheduler FSM. Strobes default low / RW to read every cycle so
  // ack and data-CE come out as single-cycle pulses. CE is issued on the
  // edge leaving WRITE, which puts it one cycle after the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      bus.o_ack          <= '0;
      bus.o_grant        <= '0;
      bus.o_uart_data_ce <= 1'b0;
      bus.o_uart_rw      <= RW_READ;
      bus.o_uart_wdata   <= '0;
      o_active           <= 1'b0;
      rr_ptr             <= IDX_W'(NUM_REQ - 1);
      owner              <= '0;
      lock_q             <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      o_err              <= 1'b0;
      wd_cnt             <= '0;
`endif
    end else begin
      bus.o_ack          <= '0;
      bus.o_uart_data_ce <= 1'b0;
      bus.o_uart_rw      <= RW_READ;
`ifdef UART_SCHED_TIMEOUT_EN
      o_err              <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (lock_q && !bus.i_lock[owner]) begin
            lock_q      <= 1'b0;
            rr_ptr      <= owner;
            bus.o_grant <= '0;
          end
          if (arb_valid) begin
            bus.o_uart_wdata <= sel_byte;
            bus.o_ack        <= arb_grant;
            bus.o_grant      <= arb_grant;
            owner            <= arb_idx;
            lock_q           <= bus.i_lock[arb_idx];
            o_active         <= 1'b1;
            state            <= WRITE;
          end
        end
        WRITE: begin
          bus.o_uart_data_ce <= 1'b1;
          bus.o_uart_rw      <= RW_WRITE;
          state              <= WAIT_BUSY;
        end
        // Busy already high here (UART still busy from elsewhere) counts
        // as the start of our byte.
        WAIT_BUSY: begin
          if (bus.i_uart_busy) state <= WAIT_IDLE;
        end
        // Locked owners keep the grant and the pointer across bytes.
        WAIT_IDLE: begin
          if (!bus.i_uart_busy) begin
            state    <= IDLE;
            o_active <= 1'b0;
            if (!lock_q) begin
              bus.o_grant <= '0;
              rr_ptr      <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef UART_SCHED_TIMEOUT_EN
      // Watchdog abort overrides whatever the case statement chose.
      if (wd_expired) begin
        state       <= IDLE;
        o_active    <= 1'b0;
        o_err       <= 1'b1;
        lock_q      <= 1'b0;
        bus.o_grant <= '0;
        rr_ptr      <= owner;
        wd_cnt      <= '0;
      end else if (wd_run) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Scoreboard bench for uart_tx_scheduler (NUM_REQ = 2, TIMEOUT_CYCLES = 100).
//   Directed stimulus pushes expected captures into a queue; a monitor on
//   the falling clock edge pops and checks each ack, the following write
//   strobe and the return to IDLE. A behavioural UART raises busy a few
//   cycles after each write strobe and drops it later.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic o_active;
  logic o_err;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_active(o_active),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [1:0] who;
    logic [7:0] data;
    logic [1:0] idle_grant;
    bit         chained;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;
  int err_count = 0;
  int ack_cycle = -100;
  int ce_cycle  = -100;
  int last_fall = -100;
  int req_cycle = 0;
  bit busy_enable = 1'b1;
  int busy_delay  = 5;
  int busy_len    = 20;
  logic prev_active = 1'b0;
  logic ce_prev     = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock,
                               input logic [7:0] d0, input logic [7:0] d1);
    bus.i_req  = req;
    bus.i_lock = lock;
    bus.i_data = {d1, d0};
  endtask

  task automatic pushExpected(input logic [1:0] who, input logic [7:0] data,
                              input logic [1:0] idle_grant, input bit chained);
    exp_t e;
    e.who        = who;
    e.data       = data;
    e.idle_grant = idle_grant;
    e.chained    = chained;
    exp_q.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ack"},    32'(bus.o_ack), 0);
    checkOutput({tag, "_grant"},  32'(bus.o_grant), 0);
    checkOutput({tag, "_ce"},     32'(bus.o_uart_data_ce), 0);
    checkOutput({tag, "_rw"},     32'(bus.o_uart_rw), 1);
    checkOutput({tag, "_wdata"},  32'(bus.o_uart_wdata), 0);
    checkOutput({tag, "_active"}, 32'(o_active), 0);
    checkOutput({tag, "_err"},    32'(o_err), 0);
  endtask

  // Called just after a rising edge; outputs are checked before any
  // further clock edge to show the reset acts asynchronously.
  task automatic applyReset(input string tag);
    #2 reset = 1'b1;
    #1 checkResetValues(tag);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic waitAcks(input int target, input int budget);
    int n = 0;
    while (ack_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ack_wait", 32'(ack_count >= target), 1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (o_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 32'(o_active), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitBusy(input logic level, input int budget);
    int n = 0;
    while (bus.i_uart_busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_level_wait", 32'(bus.i_uart_busy), 32'(level));
  endtask

  // Behavioural UART: busy rises busy_delay cycles after a write strobe
  // and stays high for busy_len cycles.
  initial begin
    bus.i_uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.o_uart_data_ce && busy_enable) begin
        repeat (busy_delay) @(posedge clk);
        #1 bus.i_uart_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.i_uart_busy = 1'b0;
        last_fall = cycle;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      prev_active = 1'b0;
      ce_prev     = 1'b0;
    end else begin
      if (ce_prev) checkOutput("ce_one_cycle", 32'(bus.o_uart_data_ce), 0);
      ce_prev = bus.o_uart_data_ce;
      if (|bus.o_ack) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", 32'(bus.o_ack), 0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("ack_vec",   32'(bus.o_ack), 32'(cur.who));
          checkOutput("grant_vec", 32'(bus.o_grant), 32'(cur.who));
          if (cur.chained)
            checkOutput("ack_after_busy_fall", cycle, last_fall + 2);
          ack_cycle = cycle;
          ack_count++;
        end
      end
      if (bus.o_uart_data_ce) begin
        checkOutput("ce_latency", cycle, ack_cycle + 1);
        checkOutput("wdata", 32'(bus.o_uart_wdata), 32'(cur.data));
        checkOutput("rw_on_write", 32'(bus.o_uart_rw), 0);
        ce_cycle = cycle;
      end
      if (prev_active && !o_active && !o_err) begin
        checkOutput("active_drop", cycle, last_fall + 1);
        checkOutput("idle_grant", 32'(bus.o_grant), 32'(cur.idle_grant));
      end
`ifdef UART_SCHED_TIMEOUT_EN
      if (o_err) begin
        checkOutput("err_timing", cycle, ce_cycle + TIMEOUT);
        checkOutput("err_active", 32'(o_active), 0);
        checkOutput("err_grant", 32'(bus.o_grant), 0);
        err_count++;
      end
`else
      if (o_err) checkOutput("err_absent", 32'(o_err), 0);
`endif
      prev_active = o_active;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int base;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    #1 reset = 1'b1;
    #2 checkResetValues("por");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Single byte from requester 0.
    @(negedge clk);
    $display("[TB] single byte");
    pushExpected(2'b01, 8'hA5, 2'b00, 1'b0);
    req_cycle = cycle;
    applyStimulus(2'b01, 2'b00, 8'hA5, 8'h00);
    waitAcks(1, 20);
    checkOutput("ack_latency", ack_cycle, req_cycle + 1);
    applyStimulus(2'b00, 2'b00, 8'hA5, 8'h00);
    waitIdle(100);

    // Contention from a fresh reset: 0,1,0,1.
    @(posedge clk);
    applyReset("pre_contention");
    @(negedge clk);
    $display("[TB] contention");
    base = ack_count;
    pushExpected(2'b01, 8'h11, 2'b00, 1'b0);
    pushExpected(2'b10, 8'h22, 2'b00, 1'b1);
    pushExpected(2'b01, 8'h11, 2'b00, 1'b1);
    pushExpected(2'b10, 8'h22, 2'b00, 1'b1);
    applyStimulus(2'b11, 2'b00, 8'h11, 8'h22);
    waitAcks(base + 4, 200);
    applyStimulus(2'b00, 2'b00, 8'h11, 8'h22);
    waitIdle(100);

    // Packet lock: requester 1 sends three bytes, then requester 0.
    $display("[TB] packet lock");
    base = ack_count;
    pushExpected(2'b10, 8'hB1, 2'b10, 1'b0);
    pushExpected(2'b10, 8'hB2, 2'b10, 1'b1);
    pushExpected(2'b10, 8'hB3, 2'b10, 1'b1);
    pushExpected(2'b01, 8'hC0, 2'b00, 1'b1);
    applyStimulus(2'b10, 2'b10, 8'hC0, 8'hB1);
    waitAcks(base + 1, 50);
    applyStimulus(2'b11, 2'b10, 8'hC0, 8'hB2);
    waitAcks(base + 2, 100);
    applyStimulus(2'b11, 2'b10, 8'hC0, 8'hB3);
    waitAcks(base + 3, 100);
    applyStimulus(2'b01, 2'b00, 8'hC0, 8'hB3);
    waitAcks(base + 4, 100);
    applyStimulus(2'b00, 2'b00, 8'hC0, 8'hB3);
    waitIdle(100);

    // Reset while waiting for busy to fall; requester 0 wins afterwards.
    $display("[TB] reset mid-byte");
    base = ack_count;
    pushExpected(2'b01, 8'h5A, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 8'h5A, 8'h00);
    waitAcks(base + 1, 20);
    applyStimulus(2'b00, 2'b00, 8'h5A, 8'h00);
    waitBusy(1'b1, 50);
    repeat (3) @(posedge clk);
    applyReset("mid_wait_idle");
    waitBusy(1'b0, 50);
    repeat (2) @(negedge clk);
    pushExpected(2'b01, 8'h77, 2'b00, 1'b0);
    applyStimulus(2'b11, 2'b00, 8'h77, 8'h88);
    waitAcks(base + 2, 20);
    applyStimulus(2'b00, 2'b00, 8'h77, 8'h88);
    waitIdle(100);

    // UART never reports busy.
    $display("[TB] busy never rises");
    busy_enable = 1'b0;
    base = ack_count;
    pushExpected(2'b01, 8'h3C, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 8'h3C, 8'h00);
    waitAcks(base + 1, 20);
    applyStimulus(2'b00, 2'b00, 8'h3C, 8'h00);
`ifdef UART_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      while (err_count == 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      checkOutput("err_seen", 32'(err_count > 0), 1);
      @(negedge clk);
      checkOutput("err_one_cycle", 32'(o_err), 0);
      checkOutput("idle_after_err", 32'(o_active), 0);
    end
`else
    repeat (150) @(negedge clk);
    checkOutput("stuck_active", 32'(o_active), 1);
    checkOutput("no_err", 32'(o_err), 0);
    checkOutput("grant_held", 32'(bus.o_grant), 32'(2'b01));
`endif

    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
